card_dealer: RTL and testbench

//  Consumer side of the BlackJack counter: takes its free-running count as a random seed and deals cards from one 52-card deck without repetition.

---
 rtl/blackjack_pkg.sv | 39 +++
 rtl/card_dealer_if.sv | 29 ++
 rtl/bj_lfsr.sv | 37 +++
 rtl/card_dealer.sv | 102 ++++++++++
 tb/tb_card_dealer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/blackjack_pkg.sv
// Shared deck constants, dealer state encoding and card-index helpers for the card dealer.
`timescale 1ns/1ps
package blackjack_pkg;

    localparam int          DECK_SIZE    = 52;
    localparam int          RANKS        = 13;
    localparam int          SUITS        = 4;
    localparam logic [11:0] LFSR_DEFAULT = 12'hACE;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PROBE      = 2'd1,
        HOLD_START = 2'd2,
        HOLD       = 2'd3
    } dealer_state_t;

    // Fold the 0..63 random draw onto the 0..51 deck range.
    function automatic logic [5:0] start_idx(input logic [5:0] s);
        return (s >= 6'd52) ? s - 6'd52 : s;
    endfunction

    function automatic logic [1:0] idx_suit(input logic [5:0] idx);
        if (idx < 6'd13)      return 2'd0;
        else if (idx < 6'd26) return 2'd1;
        else if (idx < 6'd39) return 2'd2;
        else                  return 2'd3;
    endfunction

    // Subtraction done on the low nibble: 26 and 39 are 10 and 7 modulo 16.
    function automatic logic [3:0] idx_rank(input logic [5:0] idx);
        logic [3:0] r;
        if (idx < 6'd13)      r = idx[3:0];
        else if (idx < 6'd26) r = idx[3:0] - 4'd13;
        else if (idx < 6'd39) r = idx[3:0] - 4'd10;
        else                  r = idx[3:0] - 4'd7;
        return r + 4'd1;
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Game/counter-facing signal bundle of the card dealer; slave is the dealer side.
`timescale 1ns/1ps
interface card_dealer_if #(parameter int SEED_W = 12);
    logic [SEED_W-1:0] i_Seed;
    logic              i_SeedLoad;
    logic              i_Draw;
    logic              i_Shuffle;
    logic              i_TwoSec;
    logic              o_CardValid;
    logic [3:0]        o_Rank;
    logic [1:0]        o_Suit;
    logic [5:0]        o_Remaining;
    logic              o_DeckEmpty;
    logic              o_HoldZero;
    logic              o_HoldActive;
    logic              o_Busy;

    modport master (
        output i_Seed, i_SeedLoad, i_Draw, i_Shuffle, i_TwoSec,
        input  o_CardValid, o_Rank, o_Suit, o_Remaining, o_DeckEmpty,
               o_HoldZero, o_HoldActive, o_Busy
    );

    modport slave (
        input  i_Seed, i_SeedLoad, i_Draw, i_Shuffle, i_TwoSec,
        output o_CardValid, o_Rank, o_Suit, o_Remaining, o_DeckEmpty,
               o_HoldZero, o_HoldActive, o_Busy
    );
endinterface

// File: rtl/bj_lfsr.sv
// 12-bit Fibonacci LFSR (taps 12,11,10,4) seeded from the counter; a zero seed falls back to the default.
`timescale 1ns/1ps
module bj_lfsr
    import blackjack_pkg::*;
#(
    parameter int SEED_W = 12
) (
    input  logic              clk_50M,
    input  logic              i_Reset,
    input  logic [SEED_W-1:0] seed,
    input  logic              load,
    output logic [5:0]        low_bits
);
    logic [11:0] lfsr;
    logic [11:0] seed12;
    logic        fb;

    generate
        if (SEED_W >= 12) begin : g_trunc
            assign seed12 = seed[11:0];
        end else begin : g_ext
            assign seed12 = {{(12-SEED_W){1'b0}}, seed};
        end
    endgenerate

    assign fb       = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];
    assign low_bits = lfsr[5:0];

    always_ff @(posedge clk_50M) begin
        if (i_Reset)
            lfsr <= LFSR_DEFAULT;
        else if (load)
            lfsr <= (seed12 == 12'd0) ? LFSR_DEFAULT : seed12;
        else
            lfsr <= {lfsr[10:0], fb};
    end
endmodule

// File: rtl/card_dealer.sv
// Deals cards from one 52-card deck without repetition, linear-probing a used-card bitmap
// from an LFSR start index, then holds for the counter's two-second flag.
`timescale 1ns/1ps
module card_dealer
    import blackjack_pkg::*;
#(
    parameter int SEED_W  = 12,
    parameter bit HOLD_EN = 1'b1
) (
    input  logic           clk_50M,
    input  logic           i_Reset,
    card_dealer_if.slave   bus
);
    dealer_state_t          state, state_nxt;
    logic [DECK_SIZE-1:0]   used, used_nxt;
    logic [5:0]             remaining, remaining_nxt;
    logic [5:0]             idx, idx_nxt;
    logic [3:0]             rank, rank_nxt;
    logic [1:0]             suit, suit_nxt;
    logic                   card_valid, card_valid_nxt;
    logic [5:0]             rnd;
    logic                   deck_empty;

    bj_lfsr #(.SEED_W(SEED_W)) u_lfsr (
        .clk_50M  (clk_50M),
        .i_Reset  (i_Reset),
        .seed     (bus.i_Seed),
        .load     (bus.i_SeedLoad),
        .low_bits (rnd)
    );

    assign deck_empty = (remaining == 6'd0);

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state      <= IDLE;
            used       <= '0;
            remaining  <= 6'(DECK_SIZE);
            idx        <= 6'd0;
            rank       <= 4'd0;
            suit       <= 2'd0;
            card_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            used       <= used_nxt;
            remaining  <= remaining_nxt;
            idx        <= idx_nxt;
            rank       <= rank_nxt;
            suit       <= suit_nxt;
            card_valid <= card_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        used_nxt       = used;
        remaining_nxt  = remaining;
        idx_nxt        = idx;
        rank_nxt       = rank;
        suit_nxt       = suit;
        card_valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_Shuffle) begin
                    used_nxt      = '0;
                    remaining_nxt = 6'(DECK_SIZE);
                end else if (bus.i_Draw && !deck_empty) begin
                    idx_nxt   = start_idx(rnd);
                    state_nxt = PROBE;
                end
            end
            PROBE: begin
                // Remaining > 0 on entry, so a free slot is always found within one lap.
                if (!used[idx]) begin
                    used_nxt[idx]  = 1'b1;
                    remaining_nxt  = remaining - 6'd1;
                    rank_nxt       = idx_rank(idx);
                    suit_nxt       = idx_suit(idx);
                    card_valid_nxt = 1'b1;
                    state_nxt      = HOLD_EN ? HOLD_START : IDLE;
                end else begin
                    idx_nxt = (idx == 6'(DECK_SIZE - 1)) ? 6'd0 : idx + 6'd1;
                end
            end
            HOLD_START: state_nxt = HOLD;
            HOLD: begin
                if (bus.i_TwoSec)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.o_CardValid  = card_valid;
    assign bus.o_Rank       = rank;
    assign bus.o_Suit       = suit;
    assign bus.o_Remaining  = remaining;
    assign bus.o_DeckEmpty  = deck_empty;
    assign bus.o_HoldZero   = (state == HOLD_START);
    assign bus.o_HoldActive = (state == HOLD_START) || (state == HOLD);
    assign bus.o_Busy       = (state != IDLE);
endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset, seeded draws, probe wrap, full deck, hold, shuffle and reset abort.
`timescale 1ns/1ps
module tb_card_dealer;
    logic clk_50M = 1'b0;
    logic i_Reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #10 clk_50M = ~clk_50M;

    card_dealer_if #(.SEED_W(12)) bus ();

    card_dealer #(.SEED_W(12), .HOLD_EN(1'b1)) dut (
        .clk_50M (clk_50M),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic load_seed(input logic [11:0] s);
        bus.i_Seed     = s;
        bus.i_SeedLoad = 1'b1;
        step();
        bus.i_SeedLoad = 1'b0;
    endtask

    task automatic shuffle();
        bus.i_Shuffle = 1'b1;
        step();
        bus.i_Shuffle = 1'b0;
    endtask

    // lat counts clock edges from asserting i_Draw to the edge after which o_CardValid is seen.
    task automatic draw_card(output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        bus.i_Draw = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            lat++;
            if (bus.o_CardValid) got = 1'b1;
        end
        bus.i_Draw = 1'b0;
    endtask

    task automatic release_hold();
        bus.i_TwoSec = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!bus.o_Busy) break;
        end
        bus.i_TwoSec = 1'b0;
        check_val("hold_release_busy", int'(bus.o_Busy), 0);
    endtask

    task automatic deal_seeded(input string tag, input logic [11:0] s, input int exp_suit,
                               input int exp_rank, input int exp_lat);
        int lat;
        bit got;
        load_seed(s);
        draw_card(lat, got);
        check_val({tag, "_got"}, int'(got), 1);
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_suit"}, int'(bus.o_Suit), exp_suit);
        check_val({tag, "_rank"}, int'(bus.o_Rank), exp_rank);
        release_hold();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  lat, key, bad, hz, extra, inactive;
        bit  got;
        bit  seen [52];

        i_Reset        = 1'b1;
        bus.i_Seed     = '0;
        bus.i_SeedLoad = 1'b0;
        bus.i_Draw     = 1'b0;
        bus.i_Shuffle  = 1'b0;
        bus.i_TwoSec   = 1'b0;
        repeat (3) step();
        i_Reset = 1'b0;

        // Reset state
        check_val("rst_remaining", int'(bus.o_Remaining), 52);
        check_val("rst_empty", int'(bus.o_DeckEmpty), 0);
        check_val("rst_valid", int'(bus.o_CardValid), 0);
        check_val("rst_holdzero", int'(bus.o_HoldZero), 0);
        check_val("rst_holdactive", int'(bus.o_HoldActive), 0);
        check_val("rst_busy", int'(bus.o_Busy), 0);
        check_val("rst_rank", int'(bus.o_Rank), 0);

        // Seed 0 -> 12'hACE, low six bits 14 -> suit 1, rank 2
        load_seed(12'h000);
        draw_card(lat, got);
        check_val("seed0_got", int'(got), 1);
        check_val("seed0_lat", lat, 2);
        check_val("seed0_suit", int'(bus.o_Suit), 1);
        check_val("seed0_rank", int'(bus.o_Rank), 2);
        check_val("seed0_remaining", int'(bus.o_Remaining), 51);
        check_val("seed0_holdzero", int'(bus.o_HoldZero), 1);
        check_val("seed0_holdactive", int'(bus.o_HoldActive), 1);
        release_hold();

        // Probe wrap: take idx 51 and idx 0 (52 folds to 0), then start at 51 again
        shuffle();
        deal_seeded("wrap_idx51", 12'h033, 3, 13, 2);
        deal_seeded("wrap_idx0", 12'h034, 0, 1, 2);
        deal_seeded("wrap_idx1", 12'h033, 0, 2, 4);
        check_val("wrap_remaining", int'(bus.o_Remaining), 49);

        // Full deck
        shuffle();
        foreach (seen[i]) seen[i] = 1'b0;
        for (int k = 0; k < 52; k++) begin
            draw_card(lat, got);
            check_val("deck_got", int'(got), 1);
            key = int'(bus.o_Suit) * 13 + int'(bus.o_Rank) - 1;
            check_val("deck_rank_range", int'(bus.o_Rank >= 4'd1 && bus.o_Rank <= 4'd13), 1);
            if (key >= 0 && key < 52) begin
                check_val("deck_distinct", int'(seen[key]), 0);
                seen[key] = 1'b1;
            end
            check_val("deck_remaining", int'(bus.o_Remaining), 51 - k);
            release_hold();
        end
        check_val("deck_final_remaining", int'(bus.o_Remaining), 0);
        check_val("deck_final_empty", int'(bus.o_DeckEmpty), 1);
        bad = 0;
        bus.i_Draw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.o_CardValid || bus.o_Busy) bad++;
        end
        bus.i_Draw = 1'b0;
        check_val("empty_draw_ignored", bad, 0);

        // Hold with i_Draw held high
        shuffle();
        draw_card(lat, got);
        check_val("hold_first_got", int'(got), 1);
        hz = int'(bus.o_HoldZero);
        extra = 0;
        inactive = 0;
        bus.i_Draw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            hz += int'(bus.o_HoldZero);
            if (bus.o_CardValid) extra++;
            if (!bus.o_HoldActive) inactive++;
        end
        check_val("hold_zero_pulses", hz, 1);
        check_val("hold_no_second_card", extra, 0);
        check_val("hold_active_dropouts", inactive, 0);
        bus.i_TwoSec = 1'b1;
        step();
        bus.i_TwoSec = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            lat++;
            if (bus.o_CardValid) got = 1'b1;
        end
        bus.i_Draw = 1'b0;
        check_val("hold_second_got", int'(got), 1);
        // Edge taking i_TwoSec, then IDLE sampling i_Draw, then at least one probe.
        check_val("hold_second_late", int'(lat >= 3), 1);
        release_hold();

        // Shuffle and draw in the same IDLE cycle after 10 cards
        shuffle();
        for (int k = 0; k < 10; k++) begin
            draw_card(lat, got);
            check_val("ten_got", int'(got), 1);
            release_hold();
        end
        check_val("ten_remaining", int'(bus.o_Remaining), 42);
        bus.i_Shuffle = 1'b1;
        bus.i_Draw    = 1'b1;
        step();
        bus.i_Shuffle = 1'b0;
        bus.i_Draw    = 1'b0;
        check_val("shuf_draw_remaining", int'(bus.o_Remaining), 52);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.o_CardValid || bus.o_Busy) bad++;
            step();
        end
        check_val("shuf_draw_no_card", bad, 0);

        // Reset during HOLD
        draw_card(lat, got);
        check_val("rst_hold_got", int'(got), 1);
        step();
        step();
        check_val("rst_hold_active_before", int'(bus.o_HoldActive), 1);
        i_Reset = 1'b1;
        step();
        i_Reset = 1'b0;
        check_val("rst_hold_busy", int'(bus.o_Busy), 0);
        check_val("rst_hold_active", int'(bus.o_HoldActive), 0);
        check_val("rst_hold_remaining", int'(bus.o_Remaining), 52);
        check_val("rst_hold_empty", int'(bus.o_DeckEmpty), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
